pc_sequencer: RTL and testbench

Program-counter register and fetch sequencer for the RISC-V core. Consumes the 2-bit PC-source select from branch/jump/trap resolution, computes and registers the next PC, drives the instruction-memory request handshake, and owns the `mepc` trap-return register. Sits between the execute-stage PC-source logic and the instruction memory port.

---
 rtl/pc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and instruction-fetch sequencer.
//
// Picks the next PC from the execute-stage PC-source select and drives the
// instruction-memory request handshake. It also holds the mepc trap-return
// register. A redirect that arrives while the fetch cannot advance is kept in
// a one-entry pending buffer until the next accepted fetch. Once a trap target
// is in the buffer, later redirects cannot replace it.
//
// Optional feature macro: PCSEQ_MISALIGN_TRAP_EN
//   defined   : a branch/jalr target with bit 1 set traps to i_mtvec, loads mepc
//               from i_excPC and pulses o_misaligned together with o_flush.
//   undefined : branch/jalr target bits [1:0] are forced to 00 and
//               o_misaligned stays 0.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_PCSrc             00 PC+4, 01 branch, 10 exception/mret, 11 jalr
//   i_exception/i_mret  qualify i_PCSrc=10 (exception has priority)
//   i_branchTarget      branch target address
//   i_jalrTarget        raw jalr sum; bit 0 is cleared here
//   i_mtvec, i_excPC    trap vector base, PC of the faulting instruction
//   i_stall             hold the PC
//   i_imemReady         imem accepts the current request
//   o_imemReq, o_pc     fetch request and fetch address
//   o_pcPlus4           o_pc + 4, modulo 2^XLEN
//   o_mepc              trap return address
//   o_flush             one-cycle pulse after a redirect is applied
//   o_misaligned        one-cycle pulse on a misaligned-target trap
module pc_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_PCSrc,
  input  logic            i_exception,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_branchTarget,
  input  logic [XLEN-1:0] i_jalrTarget,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_excPC,
  input  logic            i_stall,
  input  logic            i_imemReady,
  output logic            o_imemReq,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcPlus4,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_flush,
  output logic            o_misaligned
);

  typedef enum logic [1:0] {StBoot, StRun, StWait} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] buf_tgt_q, buf_tgt_d;
  logic            buf_vld_q, buf_vld_d;
  logic            buf_trap_q, buf_trap_d;
  logic            buf_mis_q, buf_mis_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] pc_plus4;
  logic            advance;
  logic            req_redir, req_trap, req_mis;
  logic [XLEN-1:0] req_tgt;

  assign pc_plus4 = pc_q + XLEN'(32'd4);
  // The request is accepted in both RUN and WAIT. That lets WAIT move the PC
  // in the same cycle that ready comes back.
  assign advance  = (state_q != StBoot) && i_imemReady && !i_stall;

  // Decode the redirect requested in this cycle.
  always_comb begin
    req_redir = 1'b0;
    req_trap  = 1'b0;
    req_mis   = 1'b0;
    req_tgt   = pc_plus4;
    unique case (i_PCSrc)
      2'b01: begin
        req_redir = 1'b1;
        req_tgt   = i_branchTarget;
      end
      2'b10: begin
        if (i_exception) begin
          req_redir = 1'b1;
          req_trap  = 1'b1;
          req_tgt   = i_mtvec;
        end else if (i_mret) begin
          req_redir = 1'b1;
          req_tgt   = mepc_q;
        end
      end
      2'b11: begin
        req_redir = 1'b1;
        req_tgt   = {i_jalrTarget[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
    // Alignment applies only to branch and jalr targets (PCSrc 01 and 11).
    if (i_PCSrc[0]) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
      if (req_tgt[1]) begin
        req_trap = 1'b1;
        req_mis  = 1'b1;
        req_tgt  = i_mtvec;
      end
`else
      req_tgt[1:0] = 2'b00;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mepc_d     = mepc_q;
    buf_tgt_d  = buf_tgt_q;
    buf_vld_d  = buf_vld_q;
    buf_trap_d = buf_trap_q;
    buf_mis_d  = buf_mis_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = i_imemReady ? StRun : StWait;
      StWait:  state_d = i_imemReady ? StRun : StWait;
      default: state_d = StBoot;
    endcase

    if (advance) begin
      if (buf_vld_q) begin
        // A pending redirect wins over this cycle's select.
        pc_d       = buf_tgt_q;
        flush_d    = 1'b1;
        mis_d      = buf_mis_q;
        buf_vld_d  = 1'b0;
        buf_trap_d = 1'b0;
        buf_mis_d  = 1'b0;
      end else if (req_redir) begin
        pc_d    = req_tgt;
        flush_d = 1'b1;
        mis_d   = req_mis;
        if (req_trap) mepc_d = i_excPC;
      end else begin
        pc_d = pc_plus4;
      end
    end else if (req_redir && !(buf_vld_q && buf_trap_q)) begin
      // Capture or overwrite. A buffered trap target cannot be replaced.
      buf_vld_d  = 1'b1;
      buf_tgt_d  = req_tgt;
      buf_trap_d = req_trap;
      buf_mis_d  = req_mis;
      if (req_trap) mepc_d = i_excPC;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      mepc_q     <= '0;
      buf_tgt_q  <= '0;
      buf_vld_q  <= 1'b0;
      buf_trap_q <= 1'b0;
      buf_mis_q  <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mepc_q     <= mepc_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_vld_q  <= buf_vld_d;
      buf_trap_q <= buf_trap_d;
      buf_mis_q  <= buf_mis_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
    end
  end

  assign o_imemReq    = (state_q != StBoot);
  assign o_pc         = pc_q;
  assign o_pcPlus4    = pc_plus4;
  assign o_mepc       = mepc_q;
  assign o_flush      = flush_q;
  // mis_q can only be set when the misaligned-trap feature is built in.
  assign o_misaligned = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk, rst_n;
  logic [1:0]  pc_src;
  logic        exc, mret, stall, ready;
  logic [31:0] br_tgt, jalr_tgt, mtvec, exc_pc;
  logic        imem_req, flush, misaligned;
  logic [31:0] pc, pc_plus4, mepc;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (ResetPc)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_PCSrc        (pc_src),
    .i_exception    (exc),
    .i_mret         (mret),
    .i_branchTarget (br_tgt),
    .i_jalrTarget   (jalr_tgt),
    .i_mtvec        (mtvec),
    .i_excPC        (exc_pc),
    .i_stall        (stall),
    .i_imemReady    (ready),
    .o_imemReq      (imem_req),
    .o_pc           (pc),
    .o_pcPlus4      (pc_plus4),
    .o_mepc         (mepc),
    .o_flush        (flush),
    .o_misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: current fetch PC, mepc, and at most one pending redirect.
  bit          m_active;
  logic [31:0] m_pc, m_mepc;
  bit          m_pend, m_pend_trap, m_pend_mis;
  logic [31:0] m_pend_tgt;
  bit          m_flush, m_mis;
  bit          n_active;
  logic [31:0] n_pc, n_mepc;
  bit          n_pend, n_pend_trap, n_pend_mis;
  logic [31:0] n_pend_tgt;
  bit          n_flush, n_mis;

  task automatic model_reset();
    m_active = 0; m_pc = ResetPc; m_mepc = 0;
    m_pend = 0; m_pend_trap = 0; m_pend_mis = 0; m_pend_tgt = 0;
    m_flush = 0; m_mis = 0;
  endtask

  task automatic model_next();
    bit          accept, redir, trap, mis;
    logic [31:0] tgt;
    accept = m_active && ready && !stall;
    redir = 0; trap = 0; mis = 0; tgt = 0;
    if (pc_src == 2'd1) begin
      redir = 1; tgt = br_tgt;
    end else if (pc_src == 2'd3) begin
      redir = 1; tgt = jalr_tgt - (jalr_tgt % 2);
    end else if (pc_src == 2'd2 && exc) begin
      redir = 1; trap = 1; tgt = mtvec;
    end else if (pc_src == 2'd2 && mret) begin
      redir = 1; tgt = m_mepc;
    end
    if (pc_src == 2'd1 || pc_src == 2'd3) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
      if ((tgt % 4) >= 2) begin trap = 1; mis = 1; tgt = mtvec; end
`else
      tgt = tgt - (tgt % 4);
`endif
    end
    n_active = 1; n_pc = m_pc; n_mepc = m_mepc;
    n_pend = m_pend; n_pend_trap = m_pend_trap; n_pend_mis = m_pend_mis;
    n_pend_tgt = m_pend_tgt; n_flush = 0; n_mis = 0;
    if (accept && m_pend) begin
      n_pc = m_pend_tgt; n_flush = 1; n_mis = m_pend_mis;
      n_pend = 0; n_pend_trap = 0; n_pend_mis = 0;
    end else if (accept && redir) begin
      n_pc = tgt; n_flush = 1; n_mis = mis;
      if (trap) n_mepc = exc_pc;
    end else if (accept) begin
      n_pc = m_pc + 32'd4;
    end else if (redir && !(m_pend && m_pend_trap)) begin
      n_pend = 1; n_pend_tgt = tgt; n_pend_trap = trap; n_pend_mis = mis;
      if (trap) n_mepc = exc_pc;
    end
  endtask

  task automatic check_all(input string where);
    check_eq({where, ".pc"}, pc, m_pc);
    check_eq({where, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check_eq({where, ".req"}, {31'd0, imem_req}, {31'd0, m_active});
    check_eq({where, ".mepc"}, mepc, m_mepc);
    check_eq({where, ".flush"}, {31'd0, flush}, {31'd0, m_flush});
    check_eq({where, ".mis"}, {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare afterwards.
  task automatic step(input string where, input logic rdy, input logic stl,
                      input logic [1:0] src, input logic ex, input logic mr,
                      input logic [31:0] bt, input logic [31:0] jt,
                      input logic [31:0] tv, input logic [31:0] epc);
    ready = rdy; stall = stl; pc_src = src; exc = ex; mret = mr;
    br_tgt = bt; jalr_tgt = jt; mtvec = tv; exc_pc = epc;
    model_next();
    @(posedge clk);
    #1;
    m_active = n_active; m_pc = n_pc; m_mepc = n_mepc;
    m_pend = n_pend; m_pend_trap = n_pend_trap; m_pend_mis = n_pend_mis;
    m_pend_tgt = n_pend_tgt; m_flush = n_flush; m_mis = n_mis;
    check_all(where);
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 0; stall = 0; pc_src = 0; exc = 0; mret = 0;
    br_tgt = 0; jalr_tgt = 0; mtvec = 0; exc_pc = 0;
    model_reset();
    #12;
    check_eq("rst.pc", pc, ResetPc);
    check_eq("rst.pc4", pc_plus4, ResetPc + 32'd4);
    check_eq("rst.req", {31'd0, imem_req}, 32'd0);
    check_eq("rst.mepc", mepc, 32'd0);
    check_eq("rst.flush", {31'd0, flush}, 32'd0);
    check_eq("rst.mis", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch.
    step("boot", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("seq.req1", {31'd0, imem_req}, 32'd1);
    check_eq("seq.pc0", pc, 32'h0);
    step("seq", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("seq.pc4", pc, 32'h4);
    step("seq", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("seq.pc8", pc, 32'h8);
    step("seq", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("seq.pcC", pc, 32'hC);

    // Branch with ready.
    step("br", 1, 0, 2'd1, 0, 0, 32'h100, 0, 0, 0);
    check_eq("br.pc", pc, 32'h100);
    check_eq("br.flush", {31'd0, flush}, 32'd1);
    step("br2", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("br.flush_off", {31'd0, flush}, 32'd0);

    // jalr captured during a wait.
    step("jw1", 0, 0, 2'd3, 0, 0, 0, 32'h205, 0, 0);
    check_eq("jw.hold1", pc, 32'h104);
    step("jw2", 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step("jw3", 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("jw.hold3", pc, 32'h104);
    step("jw4", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("jw.pc", pc, 32'h204);
    check_eq("jw.flush", {31'd0, flush}, 32'd1);

    // Exception and mret together, then mret alone.
    step("trap", 1, 0, 2'd2, 1, 1, 0, 0, 32'h80, 32'h40);
    check_eq("trap.pc", pc, 32'h80);
    check_eq("trap.mepc", mepc, 32'h40);
    step("mret", 1, 0, 2'd2, 0, 1, 0, 0, 32'h80, 32'h99);
    check_eq("mret.pc", pc, 32'h40);
    check_eq("mret.mepc", mepc, 32'h40);

    // Misaligned branch target.
    step("mis", 1, 0, 2'd1, 0, 0, 32'h102, 0, 32'h80, 32'h60);
`ifdef PCSEQ_MISALIGN_TRAP_EN
    check_eq("mis.pc", pc, 32'h80);
    check_eq("mis.flag", {31'd0, misaligned}, 32'd1);
`else
    check_eq("mis.pc", pc, 32'h100);
    check_eq("mis.flag", {31'd0, misaligned}, 32'd0);
`endif

    // Reset while a redirect is pending in WAIT.
    step("rw", 0, 0, 2'd1, 0, 0, 32'h300, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rw.req", {31'd0, imem_req}, 32'd0);
    check_eq("rw.pc", pc, ResetPc);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step("rw.boot", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step("rw.run", 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check_eq("rw.nopend", pc, ResetPc + 32'd4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tv, bt;
      tv = $urandom & 32'hFFFF_FFFC;
      bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), bt, $urandom, tv, $urandom & 32'hFFFF_FFFC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
